div_unit: RTL and testbench

- Iterative RV32M divide/remainder unit (DIV, DIVU, REM, REMU).
- Sits between the register file read ports and its write port.
- Consumes RD1/RD2 operands and returns the result plus destination index to the register file write port (WD3/A3/WE3).
- Radix-2 restoring algorithm, one quotient bit per clock, start/busy/done handshake toward the control unit.

---
 rtl/div_unit.sv | 146 ++++++++++++++
 tb/tb_div_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative RV32M divide/remainder (DIV, DIVU, REM, REMU).
// Radix-2 restoring division, one quotient bit per clock. A start/busy/done
// handshake faces the control unit, and the result plus destination index
// feed the register file write port.
// Optional build macro: DIV_ZERO_BYPASS_EN. When it is defined, a zero
// divisor or a signed overflow skips the iteration phase. Results are the
// same either way; only the latency changes.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int RD_W  = 5
) (
  input  logic             i_CLK,
  input  logic             i_Reset,
  input  logic             i_Start,
  input  logic             i_Kill,
  input  logic [1:0]       i_Op,
  input  logic [WIDTH-1:0] i_RS1,
  input  logic [WIDTH-1:0] i_RS2,
  input  logic [RD_W-1:0]  i_Rd,
  output logic             o_Busy,
  output logic             o_Done,
  output logic [WIDTH-1:0] o_Result,
  output logic [RD_W-1:0]  o_Rd,
  output logic             o_WE3
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             is_rem_q, sign_a_q, sign_b_q, div_zero_q;
  logic [RD_W-1:0]  rd_q;
  logic [WIDTH-1:0] divisor_q, rem_q, quot_q;

  // Operand preparation at issue time.
  // i_Op[0]=0 selects the signed ops, and i_Op[1]=1 selects the remainder ops.
  logic             in_signed, in_sa, in_sb, in_zero, bypass;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign in_signed = ~i_Op[0];
  assign in_sa     = in_signed & i_RS1[WIDTH-1];
  assign in_sb     = in_signed & i_RS2[WIDTH-1];
  assign mag_a     = in_sa ? -i_RS1 : i_RS1;
  assign mag_b     = in_sb ? -i_RS2 : i_RS2;
  assign in_zero   = (i_RS2 == '0);

`ifdef DIV_ZERO_BYPASS_EN
  logic in_ovf;
  assign in_ovf = in_signed && (i_RS1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_RS2 == '1);
  assign bypass = in_zero | in_ovf;
`else
  assign bypass = 1'b0;
`endif

  // One restoring step: shift {rem,quot} left, then trial-subtract the
  // divisor using one extra bit so that the borrow shows up as the MSB.
  logic [WIDTH:0] shifted, diff;
  logic           take;

  assign shifted = {rem_q, quot_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor_q};
  assign take    = ~diff[WIDTH];

  // Sign fix-up and special-case selection for the final result.
  logic [WIDTH-1:0] q_fix, r_fix, result_fix;

  assign q_fix      = div_zero_q ? '1 : ((sign_a_q ^ sign_b_q) ? -quot_q : quot_q);
  assign r_fix      = sign_a_q ? -rem_q : rem_q;
  assign result_fix = is_rem_q ? r_fix : q_fix;

  // State register.
  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next-state logic. Kill overrides every other transition.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves state_nx unassigned (no latch).
    state_nx = state;
    if (i_Kill) begin
      state_nx = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: if (i_Start) state_nx = bypass ? S_FIX : S_CALC;
        S_CALC: if (cnt == '0) state_nx = S_FIX;
        S_FIX:  state_nx = S_DONE;
        S_DONE: state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  // Datapath: operand latch at issue, iteration in CALC, result register in FIX.
  always_ff @(posedge i_CLK or posedge i_Reset) begin
    // NOTE: every datapath register is flop-based and small, so all of them get the async clear.
    if (i_Reset) begin
      cnt        <= '0;
      is_rem_q   <= 1'b0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_zero_q <= 1'b0;
      rd_q       <= '0;
      divisor_q  <= '0;
      rem_q      <= '0;
      quot_q     <= '0;
      o_Result   <= '0;
      o_Rd       <= '0;
    end else if (!i_Kill) begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      unique case (state)
        S_IDLE: if (i_Start) begin
          cnt        <= CNT_W'(WIDTH - 1);
          is_rem_q   <= i_Op[1];
          sign_a_q   <= in_sa;
          sign_b_q   <= in_sb;
          div_zero_q <= in_zero;
          rd_q       <= i_Rd;
          divisor_q  <= mag_b;
          // With the bypass, preload the final magnitudes. For a zero divisor,
          // quot is all ones and rem is |a|. For overflow, quot is |a| and rem is 0.
          rem_q      <= (bypass && in_zero) ? mag_a : '0;
          quot_q     <= (bypass && in_zero) ? '1 : mag_a;
        end
        S_CALC: begin
          cnt    <= cnt - 1'b1;
          rem_q  <= take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
          quot_q <= {quot_q[WIDTH-2:0], take};
        end
        S_FIX: begin
          o_Result <= result_fix;
          o_Rd     <= rd_q;
        end
        default: ;
      endcase
    end
  end

  // Handshake outputs decoded from the state.
  assign o_Busy = (state != S_IDLE);
  assign o_Done = (state == S_DONE);
  assign o_WE3  = o_Done & (o_Rd != '0);

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: self-checking bench for div_unit.
// Uses directed table vectors, hand-written kill/reset/ignored-start sequences,
// and random operations compared against a plain-arithmetic reference model.
module tb_div_unit;

  logic        i_CLK = 1'b0;
  logic        i_Reset = 1'b1;
  logic        i_Start = 1'b0;
  logic        i_Kill = 1'b0;
  logic [1:0]  i_Op = 2'd0;
  logic [31:0] i_RS1 = '0;
  logic [31:0] i_RS2 = '0;
  logic [4:0]  i_Rd = '0;
  logic        o_Busy, o_Done, o_WE3;
  logic [31:0] o_Result;
  logic [4:0]  o_Rd;

  int tests = 0;
  int fails = 0;

  div_unit #(.WIDTH(32), .RD_W(5)) dut (
    .i_CLK(i_CLK), .i_Reset(i_Reset), .i_Start(i_Start), .i_Kill(i_Kill),
    .i_Op(i_Op), .i_RS1(i_RS1), .i_RS2(i_RS2), .i_Rd(i_Rd),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Result(o_Result), .o_Rd(o_Rd), .o_WE3(o_WE3)
  );

  always #5 i_CLK = ~i_CLK;

  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Reference model built from the RV32M rules with native arithmetic.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb;
    logic ovf;
    sa  = a;
    sb  = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    case (op)
      OP_DIV:  return ovf ? a : 32'(sa / sb);
      OP_DIVU: return a / b;
      OP_REM:  return ovf ? 32'h0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  // Expected number of edges from E0 (exclusive) until o_Done is observed.
  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef DIV_ZERO_BYPASS_EN
    if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
`endif
    return 33;
  endfunction

  // Issues one operation from a negedge. After E0 the operand inputs are
  // scrambled. The task waits (with a bound) for o_Done, captures the
  // outputs, and returns while still at the negedge where o_Done is high.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output logic we, output int lat);
    i_Op = op; i_RS1 = a; i_RS2 = b; i_Rd = rd; i_Start = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_Start = 1'b0;
    i_RS1 = $urandom; i_RS2 = $urandom; i_Rd = 5'($urandom); i_Op = 2'($urandom);
    lat = 0;
    while (!o_Done && lat < 100) begin
      @(posedge i_CLK);
      lat++;
      @(negedge i_CLK);
    end
    if (!o_Done) check("done_timeout", 32'(lat), 32'd33);
    res = o_Result; rdo = o_Rd; we = o_WE3;
  endtask

  // Checks that o_Done lasts one cycle and that the result holds afterwards.
  task automatic check_pulse(input string name, input logic [31:0] res);
    @(posedge i_CLK);
    @(negedge i_CLK);
    check({name, "_done_pulse"}, {31'd0, o_Done}, 32'd0);
    check({name, "_busy_after"}, {31'd0, o_Busy}, 32'd0);
    check({name, "_hold"}, o_Result, res);
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  initial begin
    vec_t        vecs[$];
    logic [31:0] res, orig;
    logic [4:0]  rdo;
    logic        we;
    int          lat, dones;

    vecs.push_back('{"divu_100_7",   OP_DIVU, 32'd100,       32'd7,         5'd5,  32'd14});
    vecs.push_back('{"remu_100_7",   OP_REMU, 32'd100,       32'd7,         5'd6,  32'd2});
    vecs.push_back('{"div_m7_2",     OP_DIV,  32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFD});
    vecs.push_back('{"rem_m7_2",     OP_REM,  32'hFFFF_FFF9, 32'd2,         5'd8,  32'hFFFF_FFFF});
    vecs.push_back('{"div_7_m2",     OP_DIV,  32'd7,         32'hFFFF_FFFE, 5'd9,  32'hFFFF_FFFD});
    vecs.push_back('{"rem_7_m2",     OP_REM,  32'd7,         32'hFFFF_FFFE, 5'd10, 32'd1});
    vecs.push_back('{"div_by_zero",  OP_DIV,  32'h1234_5678, 32'd0,         5'd11, 32'hFFFF_FFFF});
    vecs.push_back('{"rem_by_zero",  OP_REM,  32'h1234_5678, 32'd0,         5'd12, 32'h1234_5678});
    vecs.push_back('{"rem_neg_by0",  OP_REM,  32'hFFFF_FFF9, 32'd0,         5'd13, 32'hFFFF_FFF9});
    vecs.push_back('{"divu_by_zero", OP_DIVU, 32'hDEAD_BEEF, 32'd0,         5'd14, 32'hFFFF_FFFF});
    vecs.push_back('{"remu_by_zero", OP_REMU, 32'hDEAD_BEEF, 32'd0,         5'd15, 32'hDEAD_BEEF});
    vecs.push_back('{"div_ovf",      OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000});
    vecs.push_back('{"rem_ovf",      OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0});
    vecs.push_back('{"divu_max_1",   OP_DIVU, 32'hFFFF_FFFF, 32'd1,         5'd18, 32'hFFFF_FFFF});
    vecs.push_back('{"divu_rd0",     OP_DIVU, 32'd100,       32'd7,         5'd0,  32'd14});

    // Reset state
    #3;
    check("rst_busy",   {31'd0, o_Busy}, 32'd0);
    check("rst_done",   {31'd0, o_Done}, 32'd0);
    check("rst_we3",    {31'd0, o_WE3},  32'd0);
    check("rst_result", o_Result, 32'd0);
    check("rst_rd",     {27'd0, o_Rd}, 32'd0);
    @(negedge i_CLK);
    i_Reset = 1'b0;
    @(negedge i_CLK);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, res, rdo, we, lat);
      check({vecs[i].name, "_result"}, res, vecs[i].exp);
      check({vecs[i].name, "_rd"}, {27'd0, rdo}, {27'd0, vecs[i].rd});
      check({vecs[i].name, "_we3"}, {31'd0, we}, {31'd0, vecs[i].rd != 0});
      check({vecs[i].name, "_latency"}, 32'(lat), 32'(exp_lat(vecs[i].op, vecs[i].a, vecs[i].b)));
      check_pulse(vecs[i].name, res);
    end

    // Start held during DONE is ignored
    run_op(OP_DIVU, 32'd1000, 32'd10, 5'd3, res, rdo, we, lat);
    check("done_start_res", res, 32'd100);
    i_Op = OP_DIVU; i_RS1 = 32'd50; i_RS2 = 32'd5; i_Rd = 5'd4; i_Start = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_Start = 1'b0;
    check("done_start_ignored", {31'd0, o_Busy}, 32'd0);

    // Start pulsed mid-CALC with new operands is ignored
    i_Op = OP_DIVU; i_RS1 = 32'd1000; i_RS2 = 32'd7; i_Rd = 5'd21; i_Start = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_Start = 1'b0;
    repeat (10) @(negedge i_CLK);
    i_Op = OP_REMU; i_RS1 = 32'd99; i_RS2 = 32'd4; i_Rd = 5'd2; i_Start = 1'b1;
    @(negedge i_CLK);
    i_Start = 1'b0;
    lat = 0;
    while (!o_Done && lat < 100) begin
      @(negedge i_CLK);
      lat++;
    end
    check("midcalc_start_res", o_Result, 32'd142);
    check("midcalc_start_rd", {27'd0, o_Rd}, 32'd21);
    @(negedge i_CLK);

    // Kill at cycle 10 of CALC
    orig = o_Result;
    i_Op = OP_DIV; i_RS1 = 32'd77; i_RS2 = 32'd3; i_Rd = 5'd9; i_Start = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_Start = 1'b0;
    repeat (9) @(negedge i_CLK);
    i_Kill = 1'b1;
    @(negedge i_CLK);
    i_Kill = 1'b0;
    check("kill_busy", {31'd0, o_Busy}, 32'd0);
    dones = 0;
    repeat (40) begin
      @(negedge i_CLK);
      if (o_Done) dones++;
    end
    check("kill_no_done", 32'(dones), 32'd0);
    check("kill_result_kept", o_Result, orig);

    // Kill wins over a simultaneous start
    i_Op = OP_DIVU; i_RS1 = 32'd9; i_RS2 = 32'd3; i_Start = 1'b1; i_Kill = 1'b1;
    @(negedge i_CLK);
    i_Start = 1'b0; i_Kill = 1'b0;
    check("kill_vs_start", {31'd0, o_Busy}, 32'd0);

    // Async reset at cycle 12 of CALC
    i_Op = OP_DIVU; i_RS1 = 32'd500; i_RS2 = 32'd9; i_Rd = 5'd30; i_Start = 1'b1;
    @(posedge i_CLK);
    @(negedge i_CLK);
    i_Start = 1'b0;
    repeat (11) @(negedge i_CLK);
    #2 i_Reset = 1'b1;
    #1;
    check("arst_busy",   {31'd0, o_Busy}, 32'd0);
    check("arst_done",   {31'd0, o_Done}, 32'd0);
    check("arst_we3",    {31'd0, o_WE3}, 32'd0);
    check("arst_result", o_Result, 32'd0);
    check("arst_rd",     {27'd0, o_Rd}, 32'd0);
    @(negedge i_CLK);
    i_Reset = 1'b0;
    @(negedge i_CLK);
    run_op(OP_REM, 32'hFFFF_FF9C, 32'd7, 5'd1, res, rdo, we, lat);
    check("post_rst_res", res, 32'hFFFF_FFFE);
    check("post_rst_we3", {31'd0, we}, 32'd1);
    @(negedge i_CLK);

    // Random operations against the reference model
    for (int n = 0; n < 40; n++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 4))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 15));
        2: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      if (n == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      run_op(op, a, b, 5'(n + 1), res, rdo, we, lat);
      check($sformatf("rand%0d_op%0d_%08h_%08h", n, op, a, b), res, ref_model(op, a, b));
      check($sformatf("rand%0d_latency", n), 32'(lat), 32'(exp_lat(op, a, b)));
      @(negedge i_CLK);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
